// File: rtl/bf16_fma_queue_pkg.sv
// Shared constants for the bfloat16 FMA command/result queue:
// register offsets, flag layout, STATUS field positions and bf16 width.
package bf16_fma_queue_pkg;

   localparam int BF16_W = 16;
   localparam int FLAG_W = 5;
   localparam int OP_W   = 3 * BF16_W;
   localparam int RES_W  = FLAG_W + BF16_W;

   localparam int FLG_INVALID   = 4;
   localparam int FLG_OVERFLOW  = 3;
   localparam int FLG_UNDERFLOW = 2;
   localparam int FLG_INEXACT   = 1;
   localparam int FLG_DENORMAL  = 0;

   localparam int ST_OPCNT_LSB  = 24;
   localparam int ST_RESCNT_LSB = 16;
   localparam int ST_OUTST_LSB  = 8;
   localparam int ST_DROP_BIT   = 7;

   typedef enum logic [1:0] {
      REG_OPAB   = 2'd0,
      REG_OPC    = 2'd1,
      REG_RESULT = 2'd2,
      REG_STATUS = 2'd3
   } reg_e;

   function automatic logic [31:0] status_word(
      input logic [7:0]        opc,
      input logic [7:0]        resc,
      input logic [7:0]        outs,
      input logic              drop,
      input logic [FLAG_W-1:0] flg
   );
      logic [31:0] w;
      w = '0;
      w[ST_OPCNT_LSB  +: 8] = opc;
      w[ST_RESCNT_LSB +: 8] = resc;
      w[ST_OUTST_LSB  +: 8] = outs;
      w[ST_DROP_BIT]        = drop;
      w[FLAG_W-1:0]         = flg;
      return w;
   endfunction

endpackage

// File: rtl/bfloat16_fma_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO, head word read combinationally from registered storage.
// Ports: clk, reset (async, active-high), push/wdata, pop/rdata, full, empty, count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q, rp_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign count   = cnt_q;
   assign rdata   = mem_q[rp_q];
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot a push into a full FIFO needs
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wp_q] <= wdata;
            wp_q        <= wp_q + 1'b1;
         end
         if (do_pop) rp_q <= rp_q + 1'b1;
         if (do_push & ~do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop & ~do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/bfloat16_fma_queue.sv
// Bus-facing operand/result queue in front of the bfloat16 FMA core.
// Ports: clk, reset; bus valid/ready/addr/wdata/wstrb/rdata; FMA op_valid/op_ready/
// op_a/op_b/op_c; res_valid/res_data/res_flags; irq (only with FMA_QUEUE_IRQ_EN).
module bfloat16_fma_queue
   import bf16_fma_queue_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   output logic              ready,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   output logic [31:0]       rdata,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [BF16_W-1:0] op_a,
   output logic [BF16_W-1:0] op_b,
   output logic [BF16_W-1:0] op_c,
   input  logic              res_valid,
   input  logic [BF16_W-1:0] res_data,
   input  logic [FLAG_W-1:0] res_flags,
   output logic              irq
);

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int CW1 = CW + 1;

   logic              ready_q, opab_q, opc_q, pop_q, clr_q;
   logic [31:0]       rdata_q, wd_q, rd_d;
   logic [BF16_W-1:0] a_q, a_d, b_q, b_d;
   logic [CW-1:0]     outs_q, outs_d, op_cnt, res_cnt;
   logic              drop_q, drop_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              req, hit, we;
   reg_e              sel;
   logic              op_full, op_empty, res_full, res_empty;
   logic [OP_W-1:0]   op_head;
   logic [RES_W-1:0]  res_head;
   logic              issue, res_acc, op_drop;
   logic [CW:0]       credit;
   logic [1:0]        unused_addr;

   assign unused_addr = addr[1:0];

   assign req = valid & ~ready_q;
   assign hit = (addr[31:4] == BASE_ADDR[31:4]);
   assign we  = |wstrb;
   assign sel = reg_e'(addr[3:2]);

   always_comb begin
      rd_d = '0;
      if (hit & ~we) begin
         unique case (sel)
            REG_RESULT: if (!res_empty) rd_d = {1'b1, 10'b0, res_head};
            REG_STATUS: rd_d = status_word(8'(op_cnt), 8'(res_cnt), 8'(outs_q), drop_q, flags_q);
            default: rd_d = '0;
         endcase
      end
   end

   // Request is decoded at the sampling edge; its side effects are pulses
   // aligned with ready and commit at the edge closing the ack cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
         opab_q  <= 1'b0;
         opc_q   <= 1'b0;
         pop_q   <= 1'b0;
         clr_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         ready_q <= req;
         rdata_q <= req ? rd_d : '0;
         opab_q  <= req & hit & we & (sel == REG_OPAB);
         opc_q   <= req & hit & we & (sel == REG_OPC);
         clr_q   <= req & hit & we & (sel == REG_STATUS);
         // only the bus pops, so non-empty now stays non-empty until commit
         pop_q   <= req & hit & ~we & (sel == REG_RESULT) & ~res_empty;
         if (req) wd_q <= wdata;
      end
   end

   assign ready = ready_q;
   assign rdata = rdata_q;

   // credit rule: a result slot is reserved for every triple in flight
   assign credit   = {1'b0, outs_q} + {1'b0, res_cnt};
   assign op_valid = ~op_empty & (credit < CW1'(DEPTH));
   assign issue    = op_valid & op_ready;
   assign res_acc  = res_valid & (outs_q != '0);
   assign op_drop  = opc_q & op_full & ~issue;
   assign {op_a, op_b, op_c} = op_head;

   sync_fifo #(.WIDTH(OP_W), .DEPTH(DEPTH)) u_op_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (opc_q),
      .pop   (issue),
      .wdata ({a_q, b_q, wd_q[BF16_W-1:0]}),
      .rdata (op_head),
      .full  (op_full),
      .empty (op_empty),
      .count (op_cnt)
   );

   sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_res_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (res_acc),
      .pop   (pop_q),
      .wdata ({res_flags, res_data}),
      .rdata (res_head),
      .full  (res_full),
      .empty (res_empty),
      .count (res_cnt)
   );

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      outs_d  = outs_q;
      drop_d  = drop_q;
      flags_d = flags_q;
      if (opab_q) begin
         a_d = wd_q[31:16];
         b_d = wd_q[15:0];
      end
      if (issue & ~res_acc)      outs_d = outs_q + 1'b1;
      else if (res_acc & ~issue) outs_d = outs_q - 1'b1;
      // a clear and a new event in the same cycle: the event wins
      if (clr_q) begin
         drop_d  = drop_q & ~wd_q[ST_DROP_BIT];
         flags_d = flags_q & ~wd_q[FLAG_W-1:0];
      end
      if (op_drop | (res_valid & ~res_acc) | (res_acc & res_full)) drop_d = 1'b1;
      if (res_acc) flags_d = flags_d | res_flags;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         outs_q  <= '0;
         drop_q  <= 1'b0;
         flags_q <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         outs_q  <= outs_d;
         drop_q  <= drop_d;
         flags_q <= flags_d;
      end
   end

`ifdef FMA_QUEUE_IRQ_EN
   logic irq_q;
   logic res_ne_d;

   // next-state non-empty, so irq tracks the FIFO with no extra lag
   assign res_ne_d = res_acc | (res_cnt > CW'(1)) | ((res_cnt == CW'(1)) & ~pop_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= res_ne_d;
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_bfloat16_fma_queue.sv
// Randomized self-checking bench for bfloat16_fma_queue against a queue-level model.
// FMA side is a procedural stub; every bus and FMA cycle is mirrored in the model.
module tb_bfloat16_fma_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h3000_0000;

   logic        clk = 0, reset = 1;
   logic        valid = 0, ready;
   logic [31:0] addr = 0, wdata = 0, rdata;
   logic [3:0]  wstrb = 0;
   logic        op_valid, op_ready = 0;
   logic [15:0] op_a, op_b, op_c;
   logic        res_valid = 0;
   logic [15:0] res_data = 0;
   logic [4:0]  res_flags = 0;
   logic        irq;

   int checks = 0, errors = 0;

   logic [47:0] m_ops[$];
   logic [47:0] m_fly[$];
   logic [20:0] m_res[$];
   logic        m_drop = 0;
   logic [4:0]  m_flags = 0;
   logic [15:0] m_a = 0, m_b = 0;

   bfloat16_fma_queue #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .ready     (ready),
      .addr      (addr),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .rdata     (rdata),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_c      (op_c),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_flags (res_flags),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      return {8'(m_ops.size()), 8'(m_res.size()), 8'(m_fly.size()), m_drop, 2'b00, m_flags};
   endfunction

   task automatic model_reset();
      m_ops.delete();
      m_fly.delete();
      m_res.delete();
      m_drop  = 0;
      m_flags = 0;
      m_a     = 0;
      m_b     = 0;
   endtask

   task automatic model_return(input logic [15:0] d, input logic [4:0] f);
      if (m_fly.size() > 0) begin
         void'(m_fly.pop_front());
         m_res.push_back({f, d});
         m_flags |= f;
      end else begin
         m_drop = 1;
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, input bit ret = 0,
                      input logic [15:0] rdat = 0, input logic [4:0] rflg = 0);
      int n;
      @(negedge clk);
      valid = 1; addr = a; wdata = d; wstrb = s;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ready && n < 8);
      rd = rdata;
      valid = 0; wstrb = 0;
      chk("ack_latency", n, 1);
      if (ret) begin
         res_valid = 1; res_data = rdat; res_flags = rflg;
      end
      @(posedge clk); #1;
      res_valid = 0;
      chk("ready_pulse", ready, 0);
   endtask

   task automatic w_opab(input logic [31:0] d);
      logic [31:0] rd;
      bus(BASE, d, 4'hF, rd);
      m_a = d[31:16];
      m_b = d[15:0];
   endtask

   task automatic w_opc(input logic [31:0] d);
      logic [31:0] rd;
      bus(BASE + 4, d, 4'hF, rd);
      if (m_ops.size() == DEPTH) m_drop = 1;
      else m_ops.push_back({m_a, m_b, d[15:0]});
   endtask

   task automatic r_result(input bit ret = 0, input logic [15:0] d = 0, input logic [4:0] f = 0);
      logic [31:0] rd, exp;
      bus(BASE + 8, 0, 4'h0, rd, ret, d, f);
      exp = (m_res.size() > 0) ? {1'b1, 10'b0, m_res[0]} : 32'h0;
      chk("result_read", rd, exp);
      if (m_res.size() > 0) void'(m_res.pop_front());
      if (ret) model_return(d, f);
   endtask

   task automatic r_status();
      logic [31:0] rd;
      bus(BASE + 12, 0, 4'h0, rd);
      chk("status_read", rd, exp_status());
   endtask

   task automatic w_status(input logic [31:0] m);
      logic [31:0] rd;
      bus(BASE + 12, m, 4'hF, rd);
      if (m[7]) m_drop = 0;
      m_flags &= ~m[4:0];
   endtask

   task automatic fma_cycle(input bit rdy, input bit rv, input logic [15:0] d, input logic [4:0] f);
      bit ev;
      @(negedge clk);
      ev = (m_ops.size() > 0) && ((m_fly.size() + m_res.size()) < DEPTH);
      chk("op_valid", op_valid, ev);
      if (ev) chk("op_abc", {op_a, op_b, op_c}, m_ops[0]);
`ifdef FMA_QUEUE_IRQ_EN
      chk("irq", irq, m_res.size() != 0);
`else
      chk("irq_off", irq, 0);
`endif
      op_ready = rdy; res_valid = rv; res_data = d; res_flags = f;
      @(posedge clk); #1;
      op_ready = 0; res_valid = 0;
      if (rv) model_return(d, f);
      if (ev && rdy) m_fly.push_back(m_ops.pop_front());
   endtask

   initial begin
      logic [31:0] rd;
      int act;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_op_valid", op_valid, 0);
      chk("rst_op_abc", {op_a, op_b, op_c}, 0);
      chk("rst_irq", irq, 0);
      @(negedge clk);
      reset = 0;
      r_status();

      w_opab(32'h3F80_4000);
      w_opc(32'h0000_3F80);
      chk("opv_after_ack", op_valid, 1);
      fma_cycle(1, 0, 0, 0);
      r_status();

      fma_cycle(0, 1, 16'h4040, 5'b00001);
      bus(BASE + 8, 0, 4'h0, rd);
      chk("result_4040", rd, 32'h8001_4040);
      void'(m_res.pop_front());
      r_result();
      r_status();
      w_status(32'h1F);
      r_status();

      for (int i = 0; i <= DEPTH; i++) begin
         w_opab($urandom);
         w_opc($urandom);
      end
      r_status();
      w_status(32'h80);

      for (int i = 0; i < DEPTH; i++) fma_cycle(1, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) fma_cycle(0, 1, 16'($urandom), 5'($urandom));
      w_opab($urandom);
      w_opc($urandom);
      fma_cycle(1, 0, 0, 0);
      fma_cycle(1, 0, 0, 0);
      r_status();
      r_result();
      fma_cycle(1, 0, 0, 0);
      r_status();

      fma_cycle(1, 1, 16'h1234, 5'b00010);
      r_status();
      r_result(1, 16'h5678, 5'b00100);
      r_status();
      while (m_fly.size() > 0) fma_cycle(0, 1, 16'($urandom), 5'($urandom));
      while (m_res.size() > 0) r_result();
      fma_cycle(0, 0, 0, 0);
      r_status();

      for (int it = 0; it < 400; it++) begin
         act = $urandom_range(0, 9);
         case (act)
            0: w_opab($urandom);
            1, 2: w_opc($urandom);
            3: r_result($urandom_range(0, 3) == 0, 16'($urandom), 5'($urandom));
            4: r_status();
            5, 6: fma_cycle($urandom_range(0, 1), $urandom_range(0, 2) == 0,
                            16'($urandom), 5'($urandom));
            7: w_status($urandom);
            8: begin
               bus(BASE + 16 + ($urandom & 32'hFFFF_FFF0), $urandom,
                   4'($urandom_range(0, 15)), rd);
               chk("oor_rdata", rd, 0);
            end
            default: begin
               bus(BASE + ($urandom_range(0, 1) * 4), 0, 4'h0, rd);
               chk("wonly_rdata", rd, 0);
               bus(BASE + 8, $urandom, 4'hF, rd);
               chk("result_wr_rdata", rd, 0);
            end
         endcase
      end
      r_status();

      for (int i = 0; i < 3; i++) begin
         w_opab($urandom);
         w_opc($urandom);
      end
      fma_cycle(1, 0, 0, 0);
      @(negedge clk);
      reset = 1;
      @(posedge clk); #1;
      chk("mid_rst_ready", ready, 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_op_valid", op_valid, 0);
      chk("mid_rst_op_abc", {op_a, op_b, op_c}, 0);
      chk("mid_rst_irq", irq, 0);
      model_reset();
      @(negedge clk);
      reset = 0;
      r_status();
      fma_cycle(1, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
